memory_cycle: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline. Sits directly downstream of the execute stage and consumes its M-side outputs.
- Holds the data memory and performs byte, half and word stores and loads with sign or zero extension.
- Detects misaligned and illegal accesses.
- Registers everything into the M/W pipeline register consumed by writeback. Also keeps load and store event counters for performance monitoring.

---
 rtl/memory_cycle.sv | 155 +++++++++++++++
 tb/tb_memory_cycle.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_cycle.sv
// memory_cycle: memory stage of the RV32I pipeline.
// Holds the byte-lane data memory, performs sized stores and extended loads,
// flags misaligned or illegal accesses, registers the M/W pipeline register,
// and counts committed loads and stores.
// There is no valid/ready handshake: every rising edge consumes one M-stage
// instruction and presents it on the W outputs one cycle later.
module memory_cycle #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [31:0] AuLu_ResultM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] AuLu_ResultW,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        MisalignW,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount
);

  logic [31:0]   mem [DEPTH];

  logic [2:0]    funct3;
  logic [1:0]    offset;
  logic [AW-1:0] idx;
  logic          store_op;
  logic          load_op;
  logic          legal;
  logic          aligned;
  logic          fault;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_val;

  // Upper address bits and non-funct3 instruction fields are intentionally ignored.
  logic          unused_bits;
  assign unused_bits = ^{ALUResultM[31:AW+2], InstrM[31:15], InstrM[11:0]};

  assign funct3 = InstrM[14:12];
  assign offset = ALUResultM[1:0];
  assign idx    = ALUResultM[AW+1:2];

  // Decode the access kind and decide whether it faults.
  // A store with ResultSrcM==01 is malformed and is treated as a store only.
  always_comb begin
    store_op = MemWriteM;
    load_op  = (ResultSrcM == 2'b01) && !MemWriteM;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~offset[0];
      2'b10:   aligned = (offset == 2'b00);
      default: aligned = 1'b1;
    endcase
    if (store_op)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else if (load_op)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    else
      legal = 1'b1;
    fault = (store_op || load_op) && !(legal && aligned);
  end

  // Byte enables and lane-replicated store data for the access size.
  always_comb begin
    byte_en = 4'b0000;
    wdata   = WriteDataM;
    case (funct3[1:0])
      2'b00: begin
        byte_en[offset] = 1'b1;
        wdata           = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{WriteDataM[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wdata   = WriteDataM;
      end
      default: begin
        byte_en = 4'b0000;
        wdata   = WriteDataM;
      end
    endcase
  end

  // Synchronous byte-lane store; memory is never cleared and writes are blocked in reset.
  always_ff @(posedge clk) begin
    if (rst && store_op && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Combinational read of the pre-edge word, then lane select and extension.
  always_comb begin
    rword = mem[idx];
    rbyte = rword[8*offset +: 8];
    rhalf = offset[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_val = {24'h000000, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_val = {16'h0000, rhalf};
      3'b010:  load_val = rword;
      default: load_val = 32'h0000_0000;
    endcase
  end

  // M/W pipeline register and event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUResultW   <= 32'h0;
      ReadDataW    <= 32'h0;
      PCPlus4W     <= 32'h0;
      AuLu_ResultW <= 32'h0;
      RdW          <= 5'h0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 2'b00;
      MisalignW    <= 1'b0;
      LoadCount    <= 32'h0;
      StoreCount   <= 32'h0;
    end else begin
      ALUResultW   <= ALUResultM;
      ReadDataW    <= (load_op && !fault) ? load_val : 32'h0;
      PCPlus4W     <= PCPlus4M;
      AuLu_ResultW <= AuLu_ResultM;
      RdW          <= RdM;
      RegWriteW    <= RegWriteM && !(load_op && fault);
      ResultSrcW   <= ResultSrcM;
      MisalignW    <= fault;
      if (load_op && !fault)  LoadCount  <= LoadCount + 32'd1;
      if (store_op && !fault) StoreCount <= StoreCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: scoreboard bench for memory_cycle with a byte-array reference model.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM, AuLu_ResultM;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, AuLu_ResultW, LoadCount, StoreCount;
  logic [4:0]  RdW;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;

  memory_cycle #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .InstrM(InstrM), .AuLu_ResultM(AuLu_ResultM), .RdM(RdM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .AuLu_ResultW(AuLu_ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .MisalignW(MisalignW),
    .LoadCount(LoadCount), .StoreCount(StoreCount)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] alu, rdata, pc4, aulu, lc, sc;
    logic [4:0]  rd;
    logic        rw, mis;
    logic [1:0]  rs;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata, last_pc4, last_aulu, last_lc, last_sc;
  logic [4:0]  last_rd;
  logic        last_rw, last_mis;
  logic [1:0]  last_rs;

  // Reference model: byte-addressed memory of DEPTH*4 bytes plus two counters.
  logic [7:0]  m_mem [4096];
  logic [31:0] m_lc = 0;
  logic [31:0] m_sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [31:0] addr, input logic [2:0] f3, input logic mw,
                            input logic [1:0] rs, input logic [31:0] wd, input logic rw,
                            output logic [31:0] rdata, output logic mis, output logic rw_out);
    int          sz;
    int          a;
    logic        is_st, is_ld, legal, ok;
    logic [31:0] v;
    is_st = mw;
    is_ld = (rs == 2'b01) && !mw;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    a     = int'(addr % 4096);
    if (is_st)      legal = (f3 <= 3'd2);
    else if (is_ld) legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else            legal = 1'b1;
    ok    = legal && ((a % sz) == 0);
    v     = 32'h0;
    if (is_ld && ok) begin
      for (int k = 0; k < sz; k++) v = v | (32'(m_mem[(a + k) % 4096]) << (8 * k));
      if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
      m_lc = m_lc + 1;
    end
    if (is_st && ok) begin
      for (int k = 0; k < sz; k++) m_mem[(a + k) % 4096] = 8'((wd >> (8 * k)) & 32'hFF);
      m_sc = m_sc + 1;
    end
    rdata  = v;
    mis    = (is_st || is_ld) && !ok;
    rw_out = rw && !(is_ld && !ok);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] addr, input logic [2:0] f3, input logic mw,
                       input logic [1:0] rs, input logic [31:0] wd, input logic rw,
                       input logic [4:0] rd, input logic [31:0] pc4, input logic [31:0] aulu);
    exp_t        e;
    logic [31:0] ins;
    @(negedge clk);
    rst          = 1'b1;
    ins          = $urandom;
    ins[14:12]   = f3;
    ALUResultM   = addr;
    WriteDataM   = wd;
    PCPlus4M     = pc4;
    InstrM       = ins;
    AuLu_ResultM = aulu;
    RdM          = rd;
    RegWriteM    = rw;
    MemWriteM    = mw;
    ResultSrcM   = rs;
    model_step(addr, f3, mw, rs, wd, rw, e.rdata, e.mis, e.rw);
    e.alu  = addr;
    e.pc4  = pc4;
    e.aulu = aulu;
    e.rd   = rd;
    e.rs   = rs;
    e.lc   = m_lc;
    e.sc   = m_sc;
    exp_q.push_back(e);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    issue(addr, f3, 1'b1, 2'b00, wd, 1'b0, 5'($urandom), $urandom, $urandom);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic rw);
    issue(addr, f3, 1'b0, 2'b01, $urandom, rw, 5'($urandom_range(1, 31)), $urandom, $urandom);
  endtask

  // Wait until the last issued instruction has been checked by the monitor.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_alu"}, ALUResultW, 32'h0);
    chk({tag, "_rdata"}, ReadDataW, 32'h0);
    chk({tag, "_pc4"}, PCPlus4W, 32'h0);
    chk({tag, "_aulu"}, AuLu_ResultW, 32'h0);
    chk({tag, "_rd"}, 32'(RdW), 32'h0);
    chk({tag, "_rw"}, 32'(RegWriteW), 32'h0);
    chk({tag, "_rs"}, 32'(ResultSrcW), 32'h0);
    chk({tag, "_mis"}, 32'(MisalignW), 32'h0);
    chk({tag, "_lc"}, LoadCount, 32'h0);
    chk({tag, "_sc"}, StoreCount, 32'h0);
  endtask

  task automatic drive_random_in_reset();
    ALUResultM   = $urandom;
    WriteDataM   = $urandom;
    PCPlus4M     = $urandom;
    InstrM       = $urandom;
    AuLu_ResultM = $urandom;
    RdM          = 5'($urandom);
    RegWriteM    = 1'($urandom);
    MemWriteM    = 1'b1;
    ResultSrcM   = 2'($urandom);
  endtask

  // ---------------- monitor ----------------
  // Every rising edge out of reset consumes one issued instruction; compare its W image.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("alu_w", ALUResultW, e.alu);
      chk("rdata_w", ReadDataW, e.rdata);
      chk("pc4_w", PCPlus4W, e.pc4);
      chk("aulu_w", AuLu_ResultW, e.aulu);
      chk("rd_w", 32'(RdW), 32'(e.rd));
      chk("regwrite_w", 32'(RegWriteW), 32'(e.rw));
      chk("resultsrc_w", 32'(ResultSrcW), 32'(e.rs));
      chk("misalign_w", 32'(MisalignW), 32'(e.mis));
      chk("load_count", LoadCount, e.lc);
      chk("store_count", StoreCount, e.sc);
      last_rdata = ReadDataW;
      last_pc4   = PCPlus4W;
      last_aulu  = AuLu_ResultW;
      last_rd    = RdW;
      last_rw    = RegWriteW;
      last_rs    = ResultSrcW;
      last_mis   = MisalignW;
      last_lc    = LoadCount;
      last_sc    = StoreCount;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    logic [2:0]  legal_f3 [5];
    int          kind;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    // Reset with random inputs toggling (including stores) keeps everything at zero.
    rst = 1'b0;
    drive_random_in_reset();
    #1;
    check_all_zero("rst_async");
    repeat (4) begin
      @(negedge clk);
      drive_random_in_reset();
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
    end

    // First transactions after release.
    st(3'd2, 32'h10, 32'hDEAD_BEEF);
    ld(3'd2, 32'h10, 1'b1);
    settle();
    chk("post_reset_lw", last_rdata, 32'hDEAD_BEEF);
    chk("post_reset_lc", last_lc, 32'd1);
    chk("post_reset_sc", last_sc, 32'd1);

    // Give the random window a known starting image.
    for (int w = 0; w < 16; w++) st(3'd2, 32'(w * 4), 32'h0);

    // Byte and half lanes.
    st(3'd0, 32'h23, 32'hFFFF_FF80);
    st(3'd1, 32'h20, 32'h1234_FFFE);
    ld(3'd2, 32'h20, 1'b1);
    settle();
    chk("lanes_lw", last_rdata, 32'h8000_FFFE);
    ld(3'd0, 32'h23, 1'b1);
    settle();
    chk("lanes_lb", last_rdata, 32'hFFFF_FF80);
    ld(3'd4, 32'h23, 1'b1);
    settle();
    chk("lanes_lbu", last_rdata, 32'h0000_0080);
    ld(3'd1, 32'h22, 1'b1);
    settle();
    chk("lanes_lh", last_rdata, 32'hFFFF_8000);
    ld(3'd5, 32'h20, 1'b1);
    settle();
    chk("lanes_lhu", last_rdata, 32'h0000_FFFE);

    // Misaligned load: no data, no register write, pulse, counter held.
    ld(3'd2, 32'h21, 1'b1);
    settle();
    chk("mis_lw_rdata", last_rdata, 32'h0);
    chk("mis_lw_rw", 32'(last_rw), 32'h0);
    chk("mis_lw_pulse", 32'(last_mis), 32'h1);
    ld(3'd2, 32'h20, 1'b1);
    settle();
    chk("mis_pulse_clears", 32'(last_mis), 32'h0);

    // Misaligned half store and illegal store leave memory untouched.
    st(3'd1, 32'h23, 32'h0000_1111);
    settle();
    chk("mis_sh_pulse", 32'(last_mis), 32'h1);
    st(3'd3, 32'h20, 32'h5555_5555);
    settle();
    chk("ill_st_pulse", 32'(last_mis), 32'h1);
    ld(3'd2, 32'h20, 1'b1);
    settle();
    chk("mis_no_write", last_rdata, 32'h8000_FFFE);

    // Address wrap modulo DEPTH*4.
    st(3'd2, 32'h1000, 32'h1234_5678);
    ld(3'd2, 32'h0000, 1'b1);
    settle();
    chk("wrap_lw", last_rdata, 32'h1234_5678);

    // Passthrough of non-memory instructions.
    issue(32'h55, 3'd2, 1'b0, 2'b10, 32'h77, 1'b1, 5'd5, 32'h104, 32'h0);
    settle();
    chk("pass_pc4", last_pc4, 32'h104);
    chk("pass_rd", 32'(last_rd), 32'd5);
    chk("pass_rs", 32'(last_rs), 32'd2);
    chk("pass_rdata", last_rdata, 32'h0);
    issue(32'h55, 3'd2, 1'b0, 2'b11, 32'h77, 1'b1, 5'd5, 32'h108, 32'hABCD_0000);
    settle();
    chk("pass_aulu", last_aulu, 32'hABCD_0000);

    // Malformed: store and load both asserted act as a store only.
    issue(32'h08, 3'd2, 1'b1, 2'b01, 32'hCAFE_F00D, 1'b1, 5'd9, 32'h0, 32'h0);
    settle();
    chk("malformed_rdata", last_rdata, 32'h0);
    chk("malformed_rw", 32'(last_rw), 32'h1);

    // Reset asserted mid-operation with a coincident store that must not commit.
    @(negedge clk);
    rst          = 1'b0;
    ALUResultM   = 32'h20;
    WriteDataM   = 32'hFFFF_FFFF;
    InstrM       = 32'h0000_2000;
    MemWriteM    = 1'b1;
    ResultSrcM   = 2'b00;
    #1;
    check_all_zero("rst_mid_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_mid_edge");
    m_lc = 0;
    m_sc = 0;
    ld(3'd2, 32'h20, 1'b1);
    settle();
    chk("rst_mid_no_write", last_rdata, 32'h8000_FFFE);
    chk("rst_mid_lc", last_lc, 32'd1);

    // Randomized traffic over a 64-byte window aliased through random high bits.
    for (int n = 0; n < 400; n++) begin
      a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      f3   = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      kind = $urandom_range(0, 9);
      if (kind < 4)       st(f3, a, $urandom);
      else if (kind < 8)  ld(f3, a, 1'($urandom));
      else if (kind == 8) issue(a, f3, 1'b1, 2'b01, $urandom, 1'($urandom), 5'($urandom), $urandom, $urandom);
      else                issue(a, f3, 1'b0, 2'($urandom_range(2, 3)), $urandom, 1'($urandom),
                                5'($urandom), $urandom, $urandom);
    end
    settle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
